npc_pipe: RTL and testbench
===========================

# npc_pipe

Pipelined next-PC unit for the five-stage MIPS core. Owns the fetch-stage PC register, resolves branches and jumps presented by decode (delay-slot semantics), and holds the PC under stall. Redirects that arrive during a stall are buffered, not lost. Replaces the single-cycle combinational next-PC logic.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_4180, redirect target for a misaligned JR target (only with NPC_ALIGN_EXC_EN)
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  hold fetch PC this cycle
- br_valid  in  1  decode presents a control-transfer instruction this cycle (one-cycle pulse per instruction)
- br_op  in  3  000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 J/JAL, 110 JR/JALR, 111 BLTZ
- cmp_a  in  32  GPR[rs] value (forwarded)
- cmp_b  in  32  GPR[rt] value (forwarded)
- imm26  in  26  instr[25:0]; branches use imm26[15:0]
- id_pc  in  32  PC of the decode-stage instruction
- pc  out  32  current fetch PC
- link_addr  out  32  id_pc + 8, combinational
- redirect_pending  out  1  buffered redirect waiting for stall to drop
- exc_adel  out  1  misaligned-JR flag (constant 0 without NPC_ALIGN_EXC_EN)

## Operation
- taken (combinational, only when br_valid): BEQ a==b; BNE a!=b; BLEZ $signed(a)<=0; BGTZ $signed(a)>0; BLTZ $signed(a)<0; J, JR always; op 000 never.
- Target: branch = id_pc + 4 + {{14{imm[15]}}, imm[15:0], 2'b00}, mod 2^32 (wrap allowed); J = {(id_pc+4)[31:28], imm26, 2'b00}; JR = cmp_a.
- States: RUN (no pending), HOLD (pending target stored in pend_tgt).
- RUN, !stall: pc <= taken ? target : pc + 4.
- RUN, stall, taken: pc holds; pend_tgt <= target; go to HOLD.
- RUN, stall, !taken: pc holds.
- HOLD, stall: pc holds; a new taken redirect overwrites pend_tgt (latest wins).
- HOLD, !stall: pc <= taken ? target : pend_tgt; go to RUN. A live taken redirect beats the buffered one.
- Not-taken branches behave as op 000. The delay slot is whatever fetch holds at id_pc+4; this block never squashes.
- pc + 4 wraps from 32'hFFFF_FFFC to 0.
- redirect_pending = (state == HOLD).

## Timing
- Reset (reset_n low at edge): pc = RESET_PC, state RUN, pend_tgt = 0, exc_adel = 0. Reset overrides stall and br_valid in the same cycle. Reset in HOLD discards the pending target.
- Redirect latency: taken in cycle N with stall low → pc = target after edge N.
- Buffered redirect: pc = pend_tgt after the first edge with stall low.
- link_addr and taken are combinational. pc, redirect_pending and exc_adel are registered.

## Configuration
- NPC_ALIGN_EXC_EN defined: a JR target with cmp_a[1:0] != 0 is replaced by EXC_VECTOR. This applies both when taken directly and when stored in pend_tgt. exc_adel is high for exactly the one cycle after the edge that loads EXC_VECTOR, and is otherwise 0.
- Not defined: the JR target is cmp_a unmodified, low bits included. exc_adel is tied to 0 and no alignment logic is synthesised.

## Test plan
- Reset: hold reset_n=0 with stall=1 and br_valid=1 → pc=32'h3000, redirect_pending=0; release → pc steps 3004, 3008 on successive edges.
- BEQ taken: id_pc=32'h3010, imm=16'hFFFC, cmp_a=cmp_b=5 → pc=32'h3004 after one edge. With cmp_b=6 → pc = previous pc + 4.
- BLTZ/BGTZ signed: cmp_a=32'h8000_0000. BLTZ taken; BGTZ and BLEZ checked against the signed rules (BGTZ not taken, BLEZ taken).
- JAL: id_pc=32'h3000, imm26=26'h0000C40 → pc=32'h0000_3100, link_addr=32'h3008.
- Stall-buffered redirect: stall=1 with JR cmp_a=32'h3400 → pc frozen, redirect_pending=1 for 3 cycles. A second JR to 32'h3500 while held → after stall drops pc=32'h3500 and redirect_pending=0. Reset asserted mid-HOLD → pc=32'h3000, pending cleared.
- NPC_ALIGN_EXC_EN: JR cmp_a=32'h3402 → pc=32'h4180, exc_adel=1 for one cycle. Without the macro → pc=32'h3402, exc_adel=0.

Source files
------------

// File: rtl/npc_pipe.sv
// Pipelined next-PC unit: fetch PC register, branch/jump resolution, stall-buffered redirects.
// Optional misaligned-JR exception redirect is enabled by defining NPC_ALIGN_EXC_EN.
module npc_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef NPC_ALIGN_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [25:0] imm26,
    input  logic [31:0] id_pc,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        redirect_pending,
    output logic        exc_adel
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;
    localparam logic [2:0] OP_BLTZ = 3'b111;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_tgt;
    logic [31:0] pend_nxt;
    logic [31:0] pc_nxt;
    logic        taken;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;

    assign seq_pc    = id_pc + 32'd4;
    assign link_addr = id_pc + 32'd8;
    assign br_tgt    = seq_pc + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign j_tgt     = {seq_pc[31:28], imm26, 2'b00};

`ifdef NPC_ALIGN_EXC_EN
    logic jr_mis;
    logic tgt_exc;
    logic pend_exc;
    logic pend_exc_nxt;
    logic exc_nxt;

    assign jr_mis  = (br_op == OP_JR) && (cmp_a[1:0] != 2'b00);
    assign jr_tgt  = jr_mis ? EXC_VECTOR : cmp_a;
    assign tgt_exc = taken && jr_mis;
`else
    assign jr_tgt   = cmp_a;
    assign exc_adel = 1'b0;
`endif

    always_comb begin
        taken = 1'b0;
        if (br_valid) begin
            case (br_op)
                OP_BEQ:  taken = (cmp_a == cmp_b);
                OP_BNE:  taken = (cmp_a != cmp_b);
                OP_BLEZ: taken = ($signed(cmp_a) <= 32'sd0);
                OP_BGTZ: taken = ($signed(cmp_a) > 32'sd0);
                OP_BLTZ: taken = ($signed(cmp_a) < 32'sd0);
                OP_J:    taken = 1'b1;
                OP_JR:   taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        target = br_tgt;
        case (br_op)
            OP_J:    target = j_tgt;
            OP_JR:   target = jr_tgt;
            default: target = br_tgt;
        endcase
    end

    // A live taken redirect always wins over the buffered one when stall drops.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_tgt;
        case (state)
            RUN: begin
                if (!stall) begin
                    pc_nxt = taken ? target : pc + 32'd4;
                end else if (taken) begin
                    pend_nxt  = target;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (taken) pend_nxt = target;
                end else begin
                    pc_nxt    = taken ? target : pend_tgt;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

`ifdef NPC_ALIGN_EXC_EN
    // Track whether the buffered target is the exception vector so exc_adel fires when it lands.
    always_comb begin
        exc_nxt      = 1'b0;
        pend_exc_nxt = pend_exc;
        case (state)
            RUN: begin
                if (!stall) exc_nxt = tgt_exc;
                else if (taken) pend_exc_nxt = tgt_exc;
            end
            HOLD: begin
                if (stall) begin
                    if (taken) pend_exc_nxt = tgt_exc;
                end else begin
                    exc_nxt = taken ? tgt_exc : pend_exc;
                end
            end
            default: exc_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_exc <= 1'b0;
            exc_adel <= 1'b0;
        end else begin
            pend_exc <= pend_exc_nxt;
            exc_adel <= exc_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            pend_tgt <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_tgt <= pend_nxt;
        end
    end

    assign redirect_pending = (state == HOLD);

endmodule

// File: tb/tb_npc_pipe.sv
// Scoreboard testbench for npc_pipe: expected pc/pending/exc queued at drive time, checked after each edge.
module tb_npc_pipe;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [25:0] imm26;
    logic [31:0] id_pc;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect_pending;
    logic        exc_adel;

    int checks = 0;
    int errors = 0;

`ifdef NPC_ALIGN_EXC_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_4180;
    localparam logic        MIS_EXC = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_3402;
    localparam logic        MIS_EXC = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pend;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    npc_pipe dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .br_valid         (br_valid),
        .br_op            (br_op),
        .cmp_a            (cmp_a),
        .cmp_b            (cmp_b),
        .imm26            (imm26),
        .id_pc            (id_pc),
        .pc               (pc),
        .link_addr        (link_addr),
        .redirect_pending (redirect_pending),
        .exc_adel         (exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input logic rn, input logic stl, input logic bv, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [25:0] imm,
                                 input logic [31:0] ipc, input string tag, input logic [31:0] epc,
                                 input logic epend, input logic eexc);
        exp_t e;
        @(negedge clk);
        reset_n  = rn;
        stall    = stl;
        br_valid = bv;
        br_op    = op;
        cmp_a    = a;
        cmp_b    = b;
        imm26    = imm;
        id_pc    = ipc;
        e.tag    = tag;
        e.pc     = epc;
        e.pend   = epend;
        e.exc    = eexc;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput({mon_e.tag, ".pc"}, pc, mon_e.pc);
            checkOutput({mon_e.tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, mon_e.pend});
            checkOutput({mon_e.tag, ".exc"}, {31'b0, exc_adel}, {31'b0, mon_e.exc});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        stall    = 1'b1;
        br_valid = 1'b1;
        br_op    = 3'b101;
        cmp_a    = '0;
        cmp_b    = '0;
        imm26    = 26'h0000C40;
        id_pc    = 32'h3000;

        // reset overrides stall and a live jump
        applyStimulus(0, 1, 1, 3'b101, 0, 0, 26'h0000C40, 32'h3000, "rst0", 32'h3000, 0, 0);
        applyStimulus(0, 1, 1, 3'b101, 0, 0, 26'h0000C40, 32'h3000, "rst1", 32'h3000, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "run1", 32'h3004, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "run2", 32'h3008, 0, 0);

        applyStimulus(1, 0, 1, 3'b001, 5, 5, 26'h000FFFC, 32'h3010, "beq_t", 32'h3004, 0, 0);
        #1 checkOutput("link_beq", link_addr, 32'h3018);
        applyStimulus(1, 0, 1, 3'b001, 5, 6, 26'h000FFFC, 32'h3010, "beq_nt", 32'h3008, 0, 0);
        applyStimulus(1, 0, 1, 3'b111, 32'h8000_0000, 0, 26'h4, 32'h3010, "bltz", 32'h3024, 0, 0);
        applyStimulus(1, 0, 1, 3'b100, 32'h8000_0000, 0, 26'h4, 32'h3010, "bgtz_neg", 32'h3028, 0, 0);
        applyStimulus(1, 0, 1, 3'b011, 32'h8000_0000, 0, 26'h4, 32'h3010, "blez_neg", 32'h3024, 0, 0);
        applyStimulus(1, 0, 1, 3'b100, 1, 0, 26'h8, 32'h3010, "bgtz_pos", 32'h3034, 0, 0);
        applyStimulus(1, 0, 1, 3'b010, 1, 2, 26'h0, 32'h3010, "bne", 32'h3014, 0, 0);
        applyStimulus(1, 0, 1, 3'b000, 0, 0, 26'h0, 32'h3010, "op_none", 32'h3018, 0, 0);
        applyStimulus(1, 0, 0, 3'b101, 0, 0, 26'h0000C40, 32'h3000, "no_valid", 32'h301C, 0, 0);
        applyStimulus(1, 0, 1, 3'b101, 0, 0, 26'h0000C40, 32'h3000, "jal", 32'h3100, 0, 0);
        #1 checkOutput("link_jal", link_addr, 32'h3008);

        // buffered redirects under stall
        applyStimulus(1, 1, 1, 3'b110, 32'h3400, 0, 0, 0, "hold1", 32'h3100, 1, 0);
        applyStimulus(1, 1, 0, 3'b000, 0, 0, 0, 0, "hold2", 32'h3100, 1, 0);
        applyStimulus(1, 1, 0, 3'b000, 0, 0, 0, 0, "hold3", 32'h3100, 1, 0);
        applyStimulus(1, 1, 1, 3'b110, 32'h3500, 0, 0, 0, "hold_ovr", 32'h3100, 1, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "release", 32'h3500, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "after_rel", 32'h3504, 0, 0);
        applyStimulus(1, 1, 1, 3'b110, 32'h3400, 0, 0, 0, "hold4", 32'h3504, 1, 0);
        applyStimulus(1, 0, 1, 3'b110, 32'h3600, 0, 0, 0, "live_wins", 32'h3600, 0, 0);
        applyStimulus(1, 1, 0, 3'b000, 0, 0, 0, 0, "stall_idle", 32'h3600, 0, 0);
        applyStimulus(1, 1, 1, 3'b001, 1, 2, 0, 0, "stall_nt", 32'h3600, 0, 0);
        applyStimulus(1, 1, 1, 3'b110, 32'h3400, 0, 0, 0, "hold5", 32'h3600, 1, 0);
        applyStimulus(0, 1, 1, 3'b110, 32'h3700, 0, 0, 0, "rst_hold", 32'h3000, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "post_rst", 32'h3004, 0, 0);

        // misaligned JR, direct and buffered
        applyStimulus(1, 0, 1, 3'b110, 32'h3402, 0, 0, 0, "jr_mis", MIS_PC, 0, MIS_EXC);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "jr_mis_next", MIS_PC + 32'd4, 0, 0);
        applyStimulus(1, 1, 1, 3'b110, 32'h3402, 0, 0, 0, "jr_mis_hold", MIS_PC + 32'd4, 1, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "jr_mis_rel", MIS_PC, 0, MIS_EXC);

        // address wrap cases
        applyStimulus(1, 0, 1, 3'b110, 32'hFFFF_FFFC, 0, 0, 0, "jr_top", 32'hFFFF_FFFC, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, "pc_wrap", 32'h0000_0000, 0, 0);
        applyStimulus(1, 0, 1, 3'b001, 7, 7, 26'h8, 32'hFFFF_FFF0, "br_wrap", 32'h0000_0014, 0, 0);
        applyStimulus(1, 0, 1, 3'b101, 0, 0, 26'h3FF_FFFF, 32'hA000_0000, "j_upper", 32'hAFFF_FFFC, 0, 0);

        @(negedge clk);
        br_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) checkOutput("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
